// File: rtl/quad_vel_est_if.sv
// Decoder-to-estimator bundle: step/dir/illegal strobes in, speed measures out.
// master = decoder/control side, slave = quad_vel_est.
interface quad_vel_est_if #(
  parameter int CNT_W    = 16,
  parameter int PERIOD_W = 24
);
  logic                       step_pulse;
  logic                       dir;
  logic                       illegal;
  logic signed [CNT_W-1:0]    vel_counts;
  logic                       vel_valid;
  logic                       win_err;
  logic signed [CNT_W-1:0]    vel_filt;
  logic        [PERIOD_W-1:0] period;
  logic                       period_valid;
  logic                       stalled;
  logic        [7:0]          err_cnt;

  modport master (
    output step_pulse, dir, illegal,
    input  vel_counts, vel_valid, win_err, vel_filt,
    input  period, period_valid, stalled, err_cnt
  );

  modport slave (
    input  step_pulse, dir, illegal,
    output vel_counts, vel_valid, win_err, vel_filt,
    output period, period_valid, stalled, err_cnt
  );
endinterface

// File: rtl/quad_vel_est.sv
// quad_vel_est: signed step count per gate window plus same-direction step period and stall detect.
// Registered outputs, 1-cycle latency, no backpressure; `VEL_FILTER_EN adds an IIR on vel_filt.
module quad_vel_est #(
  parameter int WINDOW_CYCLES = 100000,
  parameter int CNT_W         = 16,
  parameter int PERIOD_W      = 24,
  parameter int FILT_SHIFT    = 3
) (
  input  logic           clk,
  input  logic           rst,
  quad_vel_est_if.slave  est_io
);

  localparam int                      WIN_W    = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic signed [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [PERIOD_W-1:0]     GAP_MAX  = '1;

  typedef enum logic {SEED, TRACK} pstate_e;

  logic                    step, dir, illegal;
  logic [WIN_W-1:0]        win_q, win_d;
  logic                    win_end;
  logic signed [CNT_W-1:0] acc_q, acc_d, acc_next;
  logic signed [CNT_W-1:0] vel_q, vel_d;
  logic                    vel_valid_q, vel_valid_d;
  logic                    err_flag_q, err_flag_d;
  logic                    win_err_q, win_err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [PERIOD_W-1:0]     gap_q, gap_d;
  logic [PERIOD_W-1:0]     period_q, period_d;
  logic                    period_valid_q, period_valid_d;
  logic                    stalled_q, stalled_d;
  logic                    last_dir_q, last_dir_d;
  logic                    reseed_q, reseed_d;
  logic                    period_load, dir_load, stall_set;
  pstate_e                 state_q, state_d;

  assign step    = est_io.step_pulse;
  assign dir     = est_io.dir;
  assign illegal = est_io.illegal;

  // Window timer, saturating accumulator and illegal-event bookkeeping.
  always_comb begin
    win_end  = (win_q == WIN_LAST);
    win_d    = win_end ? '0 : win_q + WIN_W'(1);
    acc_next = acc_q;
    if (step && dir && (acc_q != CNT_MAX)) begin
      acc_next = acc_q + CNT_W'(1);
    end else if (step && !dir && (acc_q != CNT_MIN)) begin
      acc_next = acc_q - CNT_W'(1);
    end
    acc_d       = win_end ? '0 : acc_next;
    vel_d       = win_end ? acc_next : vel_q;
    vel_valid_d = win_end;
    err_flag_d  = win_end ? 1'b0 : (err_flag_q | illegal);
    win_err_d   = win_end ? (err_flag_q | illegal) : win_err_q;
    err_cnt_d   = (illegal && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    if (step) begin
      gap_d = PERIOD_W'(1);
    end else if (gap_q == GAP_MAX) begin
      gap_d = GAP_MAX;
    end else begin
      gap_d = gap_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEED:    if (step) state_d = TRACK;
      TRACK:   if (!step && (gap_d == GAP_MAX)) state_d = SEED;
      default: state_d = SEED;
    endcase
  end

  // A reversal stays in TRACK but marks the following step as a fresh seed.
  always_comb begin
    period_load = 1'b0;
    dir_load    = 1'b0;
    stall_set   = 1'b0;
    reseed_d    = reseed_q;
    case (state_q)
      SEED: begin
        if (step) begin
          dir_load = 1'b1;
          reseed_d = 1'b0;
        end
      end
      TRACK: begin
        if (step) begin
          if (reseed_q) begin
            dir_load = 1'b1;
            reseed_d = 1'b0;
          end else if (dir != last_dir_q) begin
            dir_load = 1'b1;
            reseed_d = 1'b1;
          end else if (!stalled_q) begin
            period_load = 1'b1;
          end
        end else if (gap_d == GAP_MAX) begin
          stall_set = 1'b1;
          reseed_d  = 1'b0;
        end
      end
      default: ;
    endcase
    period_d       = period_load ? gap_q : period_q;
    period_valid_d = period_load;
    last_dir_d     = dir_load ? dir : last_dir_q;
    stalled_d      = step ? 1'b0 : (stall_set | stalled_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q          <= '0;
      acc_q          <= '0;
      vel_q          <= '0;
      vel_valid_q    <= 1'b0;
      err_flag_q     <= 1'b0;
      win_err_q      <= 1'b0;
      err_cnt_q      <= '0;
      gap_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
      last_dir_q     <= 1'b0;
      reseed_q       <= 1'b0;
    end else begin
      win_q          <= win_d;
      acc_q          <= acc_d;
      vel_q          <= vel_d;
      vel_valid_q    <= vel_valid_d;
      err_flag_q     <= err_flag_d;
      win_err_q      <= win_err_d;
      err_cnt_q      <= err_cnt_d;
      gap_q          <= gap_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      stalled_q      <= stalled_d;
      last_dir_q     <= last_dir_d;
      reseed_q       <= reseed_d;
    end
  end

`ifdef VEL_FILTER_EN
  logic signed [CNT_W-1:0] filt_q, filt_d;
  logic signed [CNT_W:0]   filt_diff, filt_step;

  // Difference carried one bit wider so full-scale swings cannot overflow before the shift.
  always_comb begin
    filt_diff = {acc_next[CNT_W-1], acc_next} - {filt_q[CNT_W-1], filt_q};
    filt_step = filt_diff >>> FILT_SHIFT;
    filt_d    = win_end ? (filt_q + filt_step[CNT_W-1:0]) : filt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end

  assign est_io.vel_filt = filt_q;
`else
  if (FILT_SHIFT < 0) begin : g_bad_filt_shift
  end
  assign est_io.vel_filt = vel_q;
`endif

  assign est_io.vel_counts   = vel_q;
  assign est_io.vel_valid    = vel_valid_q;
  assign est_io.win_err      = win_err_q;
  assign est_io.period       = period_q;
  assign est_io.period_valid = period_valid_q;
  assign est_io.stalled      = stalled_q;
  assign est_io.err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_quad_vel_est.sv
// Directed bench: dut_a (100-cycle window, 8-bit period) and dut_b (256-cycle window, 8-bit count)
// share one stimulus stream; expected values are hand-derived cycle positions and counts.
module tb_quad_vel_est;
  logic clk = 1'b0;
  logic rst;
  logic step_r, dir_r, ill_r;
  int   n_cmp = 0;
  int   n_err = 0;
  int   tcyc  = 0;
  int   vv_a  = 0;
  int   pv_a  = 0;
  int   vv_base;
  logic [0:7] t3_dir;
  logic [0:7] t3_pv;

  always #5 clk = ~clk;

  quad_vel_est_if #(.CNT_W(16), .PERIOD_W(8))  a_if ();
  quad_vel_est_if #(.CNT_W(8),  .PERIOD_W(24)) b_if ();

  assign a_if.step_pulse = step_r;
  assign a_if.dir        = dir_r;
  assign a_if.illegal    = ill_r;
  assign b_if.step_pulse = step_r;
  assign b_if.dir        = dir_r;
  assign b_if.illegal    = ill_r;

  quad_vel_est #(.WINDOW_CYCLES(100), .CNT_W(16), .PERIOD_W(8), .FILT_SHIFT(3)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .est_io (a_if.slave)
  );

  quad_vel_est #(.WINDOW_CYCLES(256), .CNT_W(8), .PERIOD_W(24), .FILT_SHIFT(3)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .est_io (b_if.slave)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, tcyc);
    end
  endtask

  // Drives one cycle's inputs, then observes outputs #1 after the edge that consumed them.
  task automatic do_cycle(input logic s, input logic d, input logic i);
    step_r = s;
    dir_r  = d;
    ill_r  = i;
    @(posedge clk);
    #1;
    step_r = 1'b0;
    ill_r  = 1'b0;
    tcyc++;
    vv_a += int'(a_if.vel_valid);
    pv_a += int'(a_if.period_valid);
  endtask

  task automatic idle_to(input int c);
    while (tcyc < c) do_cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    step_r = 1'b0;
    dir_r  = 1'b0;
    ill_r  = 1'b0;
    t3_dir = 8'b0001_1000;
    t3_pv  = 8'b0010_0001;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_vel_counts", a_if.vel_counts, 0);
    check_eq("rst_vel_valid",  a_if.vel_valid, 0);
    check_eq("rst_period",     a_if.period, 0);
    check_eq("rst_stalled",    a_if.stalled, 0);
    check_eq("rst_err_cnt",    a_if.err_cnt, 0);
    rst  = 1'b0;
    tcyc = 0;

    // 10 CW steps at 7-cycle spacing; first step seeds, the rest report period 7.
    for (int c = 0; c < 100; c++) begin
      if ((c % 7 == 0) && (c < 70)) begin
        do_cycle(1'b1, 1'b1, 1'b0);
        if (c == 0) begin
          check_eq("pv_first_step", a_if.period_valid, 0);
        end else begin
          check_eq("pv_steady", a_if.period_valid, 1);
          check_eq("period_steady", a_if.period, 7);
        end
      end else begin
        do_cycle(1'b0, 1'b0, 1'b0);
      end
    end
    check_eq("win1_vel_valid", a_if.vel_valid, 1);
    check_eq("win1_vel_counts", a_if.vel_counts, 10);
    check_eq("win1_win_err", a_if.win_err, 0);
`ifdef VEL_FILTER_EN
    check_eq("win1_vel_filt", a_if.vel_filt, 1);
`else
    check_eq("win1_vel_filt", a_if.vel_filt, 10);
`endif
    check_eq("win1_vv_pulses", vv_a, 1);
    check_eq("win1_pv_pulses", pv_a, 9);
    do_cycle(1'b0, 1'b0, 1'b0);
    check_eq("vel_valid_one_cycle", a_if.vel_valid, 0);
    check_eq("vel_counts_hold", a_if.vel_counts, 10);

    idle_to(200);
    check_eq("empty_win_valid", a_if.vel_valid, 1);
    check_eq("empty_win_counts", a_if.vel_counts, 0);

    // Last step at cycle 63: g reaches 255 on the edge ending cycle 317.
    idle_to(317);
    check_eq("stall_not_yet", a_if.stalled, 0);
    do_cycle(1'b0, 1'b0, 1'b0);
    check_eq("stall_set", a_if.stalled, 1);
    check_eq("stall_period_hold", a_if.period, 7);
    idle_to(320);
    do_cycle(1'b1, 1'b1, 1'b0);
    check_eq("stall_clear", a_if.stalled, 0);
    check_eq("stall_clear_no_pv", a_if.period_valid, 0);
    idle_to(327);
    do_cycle(1'b1, 1'b1, 1'b0);
    check_eq("post_stall_pv", a_if.period_valid, 1);
    check_eq("post_stall_period", a_if.period, 7);

    // ACW x3 then CW, CW, ACW, ACW, ACW at 5-cycle spacing; reversals re-seed.
    for (int k = 0; k < 8; k++) begin
      idle_to(332 + 5 * k);
      do_cycle(1'b1, t3_dir[k], 1'b0);
      check_eq($sformatf("rev_pv_%0d", k), a_if.period_valid, t3_pv[k]);
      if (t3_pv[k]) check_eq($sformatf("rev_period_%0d", k), a_if.period, 5);
    end
    idle_to(400);
    check_eq("neg_win_valid", a_if.vel_valid, 1);
    check_eq("neg_win_counts", a_if.vel_counts, -2);

    // 200 back-to-back CW steps, one carrying a coincident illegal strobe.
    idle_to(512);
    for (int c = 512; c < 712; c++) begin
      do_cycle(1'b1, 1'b1, c == 600);
      if (c == 599) check_eq("a_win_88", a_if.vel_counts, 88);
      if (c == 600) begin
        check_eq("a_err_cnt", a_if.err_cnt, 1);
        check_eq("b_err_cnt", b_if.err_cnt, 1);
      end
      if (c == 699) begin
        check_eq("a_win_100", a_if.vel_counts, 100);
        check_eq("a_win_err", a_if.win_err, 1);
      end
    end
    idle_to(768);
    check_eq("b_sat_valid", b_if.vel_valid, 1);
    check_eq("b_sat_counts", b_if.vel_counts, 127);
    check_eq("b_win_err", b_if.win_err, 1);

    // Mid-window reset with 5 steps accumulated.
    idle_to(800);
    for (int k = 0; k < 5; k++) do_cycle(1'b1, 1'b1, 1'b0);
    idle_to(810);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_err_cnt", a_if.err_cnt, 0);
    check_eq("mid_rst_period", a_if.period, 0);
    check_eq("mid_rst_b_counts", b_if.vel_counts, 0);
    check_eq("mid_rst_b_win_err", b_if.win_err, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_rst_vel_valid", a_if.vel_valid, 0);
    rst     = 1'b0;
    tcyc    = 0;
    vv_base = vv_a;
    for (int k = 1; k <= 3; k++) begin
      idle_to(10 * k);
      do_cycle(1'b1, 1'b1, 1'b0);
      if (k == 1) check_eq("post_rst_seed_pv", a_if.period_valid, 0);
      if (k == 2) check_eq("post_rst_period", a_if.period, 10);
    end
    idle_to(99);
    check_eq("post_rst_no_spurious", vv_a - vv_base, 0);
    do_cycle(1'b0, 1'b0, 1'b0);
    check_eq("post_rst_valid", a_if.vel_valid, 1);
    check_eq("post_rst_counts", a_if.vel_counts, 3);
    check_eq("post_rst_win_err", a_if.win_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
